// File: rtl/register_file.sv
// Multi-entry register file: one synchronous write port and one combinational read port.
// Every entry loads RESET_VALUE asynchronously while rst is high.
module register_file #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 3,
  parameter int                    DEPTH       = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("register_file: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] entry [DEPTH];

  // One register per implemented entry; an address that decodes to no entry drops the write.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry[i] <= RESET_VALUE;
      end else if (we && (write_addr == ADDR_WIDTH'(i))) begin
        entry[i] <= write_data;
      end
    end
  end

  // Unimplemented addresses read as zero; there is no write-to-read bypass.
  always_comb begin
    read_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (read_addr == ADDR_WIDTH'(i)) begin
        read_data = entry[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table, multi-cycle corner cases and
// randomized traffic against an array model, on a full-depth and a partial-depth instance.
`timescale 1ns/1ps
module tb_register_file;

  localparam int D2 = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [2:0] read_addr;
  logic [7:0] read_data;
  logic [7:0] read_data2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] m1 [8];
  logic [7:0] m2 [D2];

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [7];

  register_file dut (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data)
  );

  register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(D2), .RESET_VALUE(8'h3C)) dut2 (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: read_addr=%0d got %h expected %h", name, read_addr, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m1[i] = 8'h00;
    for (int i = 0; i < D2; i++) m2[i] = 8'h3C;
  endtask

  function automatic logic [7:0] exp2(input logic [2:0] a);
    return (int'(a) < D2) ? m2[a] : 8'h00;
  endfunction

  task automatic check_both(input string name);
    check({name, "_d8"}, read_data, m1[read_addr]);
    check({name, "_d5"}, read_data2, exp2(read_addr));
  endtask

  // Drive one cycle from the falling edge, let the rising edge happen, update the model.
  task automatic cycle(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] ra);
    @(negedge clk);
    we = w; write_addr = wa; write_data = wd; read_addr = ra;
    @(posedge clk);
    if (w && !rst) begin
      m1[wa] = wd;
      if (int'(wa) < D2) m2[wa] = wd;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; write_addr = '0; write_data = '0; read_addr = '0;
    model_reset();

    vecs[0] = '{1'b1, 3'd1, 8'hA5, 3'd1, 8'hA5};
    vecs[1] = '{1'b1, 3'd2, 8'h5A, 3'd2, 8'h5A};
    vecs[2] = '{1'b0, 3'd3, 8'hFF, 3'd1, 8'hA5};
    vecs[3] = '{1'b0, 3'd3, 8'hFF, 3'd3, 8'h00};
    vecs[4] = '{1'b0, 3'd3, 8'hFF, 3'd2, 8'h5A};
    vecs[5] = '{1'b0, 3'd3, 8'hFF, 3'd0, 8'h00};
    vecs[6] = '{1'b0, 3'd3, 8'hFF, 3'd3, 8'h00};

    // Reset state, read while rst is held high.
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      read_addr = 3'(a); #1;
      check_both("reset_sweep");
    end
    @(negedge clk); rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra);
      check($sformatf("vec%0d", i), read_data, vecs[i].exp);
      check($sformatf("vec%0d_d5", i), read_data2, exp2(read_addr));
    end

    // Read during write to the same address: old value before the edge, new after.
    @(negedge clk);
    read_addr = 3'd4; we = 1'b1; write_addr = 3'd4; write_data = 8'h3C; #1;
    check("rdw_before", read_data, 8'h00);
    @(posedge clk); #1;
    check("rdw_after", read_data, 8'h3C);
    m1[4] = 8'h3C;
    cycle(1'b1, 3'd4, 8'hC3, 3'd4);
    check("rdw_overwrite", read_data, 8'hC3);

    // Fill everything, then pulse rst between edges.
    for (int a = 0; a < 8; a++) cycle(1'b1, 3'(a), 8'h10 + 8'(a), 3'(a));
    cycle(1'b0, 3'd0, 8'h00, 3'd7);
    check("fill_last", read_data, 8'h17);
    @(negedge clk); #1;
    rst = 1'b1; model_reset(); #1;
    check_both("async_clear_now");
    for (int a = 0; a < 8; a++) begin
      read_addr = 3'(a); #0.25;
      check_both("async_clear_sweep");
    end
    // Write with rst high at the edge must be discarded.
    @(negedge clk);
    we = 1'b1; write_addr = 3'd5; write_data = 8'hEE; read_addr = 3'd5;
    @(posedge clk); #1;
    check("write_in_reset", read_data, 8'h00);
    @(negedge clk);
    rst = 1'b0; write_addr = 3'd6; write_data = 8'h77; read_addr = 3'd6; #1;
    check("post_reset_pre", read_data, 8'h00);
    @(posedge clk); #1;
    m1[6] = 8'h77;
    check("first_write_after_reset", read_data, 8'h77);
    @(negedge clk); we = 1'b0;

    // Full sweep of address-dependent patterns.
    for (int a = 0; a < 8; a++) cycle(1'b1, 3'(a), 8'(a) ^ 8'h96, 3'd0);
    @(negedge clk); we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      read_addr = 3'(a); #1;
      check("sweep", read_data, 8'(a) ^ 8'h96);
      check("sweep_d5", read_data2, exp2(read_addr));
    end

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      write_addr = 3'($urandom_range(0, 7));
      write_data = 8'($urandom);
      read_addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1; model_reset();
      end else begin
        rst = 1'b0;
      end
      #1;
      check_both("rand_pre");
      @(posedge clk);
      if (we && !rst) begin
        m1[write_addr] = write_data;
        if (int'(write_addr) < D2) m2[write_addr] = write_data;
      end
      #1;
      check_both("rand_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
